// File: rtl/fp_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_pkg
//  Brief    : Shared definitions for the FP operand path: default field widths,
//             skid-register occupancy state and the operand class record.
//  Revision : 1.0  initial release
// ============================================================================
package fp_pkg;

    localparam int SP_EXP_W = 8;
    localparam int SP_MAN_W = 23;
    localparam int HP_EXP_W = 5;
    localparam int HP_MAN_W = 10;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic zero;
        logic denorm;
        logic inf;
        logic nan;
    } fp_class_t;

endpackage : fp_pkg
`default_nettype wire

// File: rtl/fp_classify.sv
`default_nettype none
// ============================================================================
//  Module   : fp_classify
//  Brief    : Combinational IEEE-754-style class decode of exponent/fraction.
//  Revision : 1.0  initial release
// ============================================================================
module fp_classify
    import fp_pkg::*;
#(
    parameter int EXP_W = SP_EXP_W,
    parameter int MAN_W = SP_MAN_W
) (
    input  logic [EXP_W-1:0] exp_i,
    input  logic [MAN_W-1:0] frac_i,
    output fp_class_t        cls_o
);

    logic w_exp_zero;
    logic w_exp_ones;
    logic w_frac_zero;

    assign w_exp_zero  = (exp_i == '0);
    assign w_exp_ones  = &exp_i;
    assign w_frac_zero = (frac_i == '0);

    assign cls_o.zero   = w_exp_zero &  w_frac_zero;
    assign cls_o.denorm = w_exp_zero & ~w_frac_zero;
    assign cls_o.inf    = w_exp_ones &  w_frac_zero;
    assign cls_o.nan    = w_exp_ones & ~w_frac_zero;

endmodule : fp_classify
`default_nettype wire

// File: rtl/fp_operand_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_operand_skid_reg
//  Brief    : Two-entry valid/ready skid register capturing packed FP operands
//             and presenting the head both packed and unpacked.
//             Optional class flags are built when FP_CLASSIFY_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module fp_operand_skid_reg
    import fp_pkg::*;
#(
    parameter int EXP_W  = SP_EXP_W,
    parameter int MAN_W  = SP_MAN_W,
    parameter int DATA_W = 1 + EXP_W + MAN_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sign,
    output logic [EXP_W-1:0]  out_exp,
    output logic [MAN_W:0]    out_man,
`ifdef FP_CLASSIFY_EN
    output logic              out_is_zero,
    output logic              out_is_denorm,
    output logic              out_is_inf,
    output logic              out_is_nan,
`endif
    output logic [1:0]        count
);

    skid_state_e       state_q, state_d;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;

    logic w_accept;
    logic w_pop;
    logic w_load_main_in;
    logic w_load_skid;
    logic w_main_from_skid;

    assign in_ready  = (state_q != ST_FULL);
    assign out_valid = (state_q != ST_EMPTY);
    assign count     = state_q;

    assign w_accept = in_valid & in_ready;
    assign w_pop    = out_valid & out_ready;

    always_comb begin
        state_d          = state_q;
        w_load_main_in   = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (w_accept) begin
                        state_d        = ST_ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_pop) begin
                        w_load_main_in = 1'b1;
                    end else if (w_accept) begin
                        state_d     = ST_FULL;
                        w_load_skid = 1'b1;
                    end else if (w_pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // in_ready is low here, so a pop can only drain the skid.
                    if (w_pop) begin
                        state_d          = ST_ONE;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (w_load_main_in) begin
                main_q <= in_data;
            end else if (w_main_from_skid) begin
                main_q <= skid_q;
            end
            if (w_load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    assign out_data = main_q;
    assign out_sign = main_q[DATA_W-1];
    assign out_exp  = main_q[DATA_W-2:MAN_W];
    assign out_man  = {|out_exp, main_q[MAN_W-1:0]};

`ifdef FP_CLASSIFY_EN
    fp_class_t w_in_cls;
    fp_class_t main_cls_q;
    fp_class_t skid_cls_q;

    fp_classify #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_fp_classify (
        .exp_i  (in_data[DATA_W-2:MAN_W]),
        .frac_i (in_data[MAN_W-1:0]),
        .cls_o  (w_in_cls)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_cls_q <= '0;
            skid_cls_q <= '0;
        end else begin
            if (w_load_main_in) begin
                main_cls_q <= w_in_cls;
            end else if (w_main_from_skid) begin
                main_cls_q <= skid_cls_q;
            end
            if (w_load_skid) begin
                skid_cls_q <= w_in_cls;
            end
        end
    end

    assign out_is_zero   = out_valid & main_cls_q.zero;
    assign out_is_denorm = out_valid & main_cls_q.denorm;
    assign out_is_inf    = out_valid & main_cls_q.inf;
    assign out_is_nan    = out_valid & main_cls_q.nan;
`endif

endmodule : fp_operand_skid_reg
`default_nettype wire

// File: tb/tb_fp_operand_skid_reg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fp_operand_skid_reg
//  Brief    : Directed self-checking bench for fp_operand_skid_reg (SP widths).
//             Class-flag checks are built when FP_CLASSIFY_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fp_operand_skid_reg;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sign;
    logic [7:0]  out_exp;
    logic [23:0] out_man;
    logic [1:0]  count;
`ifdef FP_CLASSIFY_EN
    logic        out_is_zero;
    logic        out_is_denorm;
    logic        out_is_inf;
    logic        out_is_nan;
`endif

    int n_checks = 0;
    int n_errors = 0;

    fp_operand_skid_reg dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sign  (out_sign),
        .out_exp   (out_exp),
        .out_man   (out_man),
`ifdef FP_CLASSIFY_EN
        .out_is_zero   (out_is_zero),
        .out_is_denorm (out_is_denorm),
        .out_is_inf    (out_is_inf),
        .out_is_nan    (out_is_nan),
`endif
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] v;
        reset     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_count",     {30'd0, count}, 32'd0);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  out_data, 32'd0);
        check("rst_out_man",   {8'd0, out_man}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready}, 32'd1);
        reset = 1'b1;
        @(negedge clk);

        // Single operand, latency 1
        in_valid = 1'b1; in_data = 32'h3F80_0000; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("t1_out_valid", {31'd0, out_valid}, 32'd1);
        check("t1_sign",      {31'd0, out_sign}, 32'd0);
        check("t1_exp",       {24'd0, out_exp}, 32'h7F);
        check("t1_man",       {8'd0, out_man}, 32'h80_0000);
        check("t1_count",     {30'd0, count}, 32'd1);
        @(negedge clk);
        check("t1_drained",   {30'd0, count}, 32'd0);

        // Fill to FULL under backpressure, then drain in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h4000_0000;
        @(negedge clk);
        check("t2_count_a",   {30'd0, count}, 32'd1);
        in_data = 32'hC040_0000;
        @(negedge clk);
        in_valid = 1'b0;
        check("t2_count_full", {30'd0, count}, 32'd2);
        check("t2_in_ready",   {31'd0, in_ready}, 32'd0);
        check("t2_head_held",  out_data, 32'h4000_0000);
        @(negedge clk);
        check("t2_hold_stable", out_data, 32'h4000_0000);
        out_ready = 1'b1;
        @(negedge clk);
        check("t2_head_b",   out_data, 32'hC040_0000);
        check("t2_sign_b",   {31'd0, out_sign}, 32'd1);
        check("t2_count_b",  {30'd0, count}, 32'd1);
        @(negedge clk);
        check("t2_empty",    {30'd0, count}, 32'd0);
        check("t2_out_valid", {31'd0, out_valid}, 32'd0);

        // Streaming: one operand per cycle, no bubbles
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v = {1'b0, 8'(8'h70 + i), 23'(i * 3 + 1)};
            in_data = v;
            @(negedge clk);
            check("t3_stream_valid", {31'd0, out_valid}, 32'd1);
            check("t3_stream_data",  out_data, v);
            check("t3_stream_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("t3_drained", {30'd0, count}, 32'd0);

        // Flush from FULL with a concurrent input
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h4000_0000;
        @(negedge clk);
        in_data = 32'hC040_0000;
        @(negedge clk);
        check("t4_full", {30'd0, count}, 32'd2);
        flush = 1'b1; in_data = 32'h3F00_0000;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("t4_count",     {30'd0, count}, 32'd0);
        check("t4_out_valid", {31'd0, out_valid}, 32'd0);
        check("t4_in_ready",  {31'd0, in_ready}, 32'd1);

        // Flush from ONE: the operand offered alongside flush is dropped
        in_valid = 1'b1; in_data = 32'h4000_0000;
        @(negedge clk);
        flush = 1'b1; in_data = 32'h3F00_0000;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("t4b_count", {30'd0, count}, 32'd0);
        repeat (2) @(negedge clk);
        check("t4b_no_ghost", {31'd0, out_valid}, 32'd0);

        // Denormal unpack: hidden bit clear
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h0000_0001;
        @(negedge clk);
        in_valid = 1'b0;
        check("t5_denorm_man", {8'd0, out_man}, 32'h00_0001);
        check("t5_denorm_exp", {24'd0, out_exp}, 32'd0);
        out_ready = 1'b1;
        @(negedge clk);

`ifdef FP_CLASSIFY_EN
        begin
            logic [31:0] vec [4];
            logic [3:0]  cls [4];
            vec[0] = 32'h7FC0_0000; cls[0] = 4'b0001;
            vec[1] = 32'h7F80_0000; cls[1] = 4'b0010;
            vec[2] = 32'h0000_0001; cls[2] = 4'b0100;
            vec[3] = 32'h8000_0000; cls[3] = 4'b1000;
            for (int k = 0; k < 4; k++) begin
                out_ready = 1'b0;
                in_valid = 1'b1; in_data = vec[k];
                @(negedge clk);
                in_valid = 1'b0;
                check("t6_class", {28'd0, out_is_zero, out_is_denorm, out_is_inf, out_is_nan},
                      {28'd0, cls[k]});
                if (k == 3) check("t6_zero_sign", {31'd0, out_sign}, 32'd1);
                out_ready = 1'b1;
                @(negedge clk);
                check("t6_class_idle", {28'd0, out_is_zero, out_is_denorm, out_is_inf, out_is_nan},
                      32'd0);
            end
        end
`endif

        // Asynchronous reset while FULL
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 32'h4000_0000;
        @(negedge clk);
        in_data = 32'hC040_0000;
        @(negedge clk);
        in_valid = 1'b0;
        check("t7_full", {30'd0, count}, 32'd2);
        #2 reset = 1'b0;
        #1;
        check("t7_async_count",     {30'd0, count}, 32'd0);
        check("t7_async_out_valid", {31'd0, out_valid}, 32'd0);
        check("t7_async_out_data",  out_data, 32'd0);
        check("t7_async_in_ready",  {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h3F80_0000; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("t7_after_data",  out_data, 32'h3F80_0000);
        check("t7_after_exp",   {24'd0, out_exp}, 32'h7F);
        check("t7_after_count", {30'd0, count}, 32'd1);
        @(negedge clk);
        check("t7_final_empty", {30'd0, count}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fp_operand_skid_reg
`default_nettype wire
